mem_access_unit: RTL and testbench

Load/store unit sitting directly downstream of the ALU in the single-cycle core. It takes the ALU result as an effective address plus rs2 store data, runs one transaction on a word-wide data bus with variable wait states, and returns sign- or zero-extended load data. While the access is outstanding it asserts `stall` so the PC and register-file write are held.

---
 rtl/mem_access_unit.sv | 213 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit: turns an ALU effective address and rs2 data into one word-bus transaction.
// Latency: 2 + bus wait cycles from accept to resp_valid; 1 cycle for misaligned or illegal-size requests.
// Backpressure: req_ready only in IDLE; stall holds the core while the access is outstanding.
//
// Ports:
//   cpu_clk, cpu_rst                 clock and synchronous active-high reset
//   req_valid/we/size/unsigned/addr/wdata   request from the core (sampled in IDLE only)
//   req_ready, stall                 accept indication and core hold
//   resp_valid/rdata/err             one-cycle completion with extended load data
//   bus_req/we/addr/wstrb/wdata      registered word-bus request, stable until ack
//   bus_ack, bus_rdata               bus completion and read word
//
// Optional feature: define LSU_TIMEOUT_EN to abort a BUS access after
// TIMEOUT_CYCLES cycles without bus_ack (reported as resp_err).
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_access_unit: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic        req_ready_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  bus_wstrb_q;
  logic [31:0] bus_wdata_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;

`ifdef LSU_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q;
`endif

  // Request decode (IDLE side) and load extraction (BUS side).
  logic        bad_d;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;
  logic [31:0] byte_shift;
  logic [15:0] half_sel;
  logic [31:0] rdata_ext_d;

  always_comb begin
    bad_d = (req_size == 2'b11) ||
            (req_size == 2'b01 && req_addr[0]) ||
            (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    wstrb_d = 4'b0000;
    wdata_d = 32'h0;
    if (req_we) begin
      case (req_size)
        2'b00: begin
          wstrb_d = 4'b0001 << req_addr[1:0];
          wdata_d = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          wstrb_d = 4'b0011 << req_addr[1:0];
          wdata_d = {2{req_wdata[15:0]}};
        end
        default: begin
          wstrb_d = 4'b1111;
          wdata_d = req_wdata;
        end
      endcase
    end

    // Byte lane selected by the low address bits, half lane by addr[1].
    byte_shift = bus_rdata >> {lane_q, 3'b000};
    half_sel   = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_q)
      2'b00:   rdata_ext_d = {{24{~uns_q & byte_shift[7]}}, byte_shift[7:0]};
      2'b01:   rdata_ext_d = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: rdata_ext_d = bus_rdata;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'h0;
      bus_wstrb_q  <= 4'b0000;
      bus_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      lane_q       <= 2'b00;
`ifdef LSU_TIMEOUT_EN
      cnt_q        <= 16'h0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            size_q      <= req_size;
            uns_q       <= req_unsigned;
            lane_q      <= req_addr[1:0];
            req_ready_q <= 1'b0;
            if (bad_d) begin
              // Rejected without touching the bus.
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
            end else begin
              state_q     <= ST_BUS;
              bus_req_q   <= 1'b1;
              bus_we_q    <= req_we;
              bus_addr_q  <= {req_addr[31:2], 2'b00};
              bus_wstrb_q <= wstrb_d;
              bus_wdata_q <= wdata_d;
`ifdef LSU_TIMEOUT_EN
              cnt_q       <= 16'h0;
`endif
            end
          end
        end

        ST_BUS: begin
          if (bus_ack) begin
            state_q      <= ST_RESP;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_wstrb_q  <= 4'b0000;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= bus_we_q ? 32'h0 : rdata_ext_d;
          end
`ifdef LSU_TIMEOUT_EN
          // An ack in the final cycle takes priority over the abort above.
          else if (cnt_q == TO_LAST) begin
            state_q      <= ST_RESP;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_wstrb_q  <= 4'b0000;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= 32'h0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
`else
          // Without the watchdog the access waits for bus_ack indefinitely.
`endif
        end

        ST_RESP: begin
          state_q      <= ST_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0;
        end

        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Low in RESP so the core consumes resp_rdata and advances that cycle.
  assign stall      = (state_q == ST_IDLE && req_valid) || (state_q == ST_BUS);
  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wstrb  = bus_wstrb_q;
  assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  always #5 cpu_clk = ~cpu_clk;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .cpu_clk      (cpu_clk),
    .cpu_rst      (cpu_rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .stall        (stall),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wstrb    (bus_wstrb),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample and drive 1 time unit after the rising edge.
  task automatic tick;
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
  endtask

  // Zero-wait load: accept, ack in first BUS cycle, check the RESP cycle.
  task automatic load_chk(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] rd,
                          input logic [31:0] exp);
    logic [31:0] word_addr;
    word_addr = {addr[31:2], 2'b00};
    issue(1'b0, sz, uns, addr, 32'h0);
    tick;
    req_valid = 1'b0;
    chk({tag, "/bus_req"}, {31'h0, bus_req}, 32'h1);
    chk({tag, "/bus_addr"}, bus_addr, word_addr);
    chk({tag, "/bus_wstrb"}, {28'h0, bus_wstrb}, 32'h0);
    bus_ack   = 1'b1;
    bus_rdata = rd;
    tick;
    bus_ack = 1'b0;
    chk({tag, "/resp_valid"}, {31'h0, resp_valid}, 32'h1);
    chk({tag, "/resp_rdata"}, resp_rdata, exp);
    chk({tag, "/resp_err"}, {31'h0, resp_err}, 32'h0);
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stall_cnt;
    int n;

    cpu_rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    tick; tick;

    // Reset state
    chk("rst/req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst/bus_req", {31'h0, bus_req}, 32'h0);
    chk("rst/resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst/bus_wstrb", {28'h0, bus_wstrb}, 32'h0);
    chk("rst/resp_rdata", resp_rdata, 32'h0);
    chk("rst/stall_lo", {31'h0, stall}, 32'h0);
    cpu_rst = 1'b0;
    req_valid = 1'b1;
    #1;
    chk("idle/stall_follows_valid", {31'h0, stall}, 32'h1);
    req_valid = 1'b0;
    #1;
    chk("idle/stall_low", {31'h0, stall}, 32'h0);
    tick;

    // Word load
    load_chk("lw", 2'b10, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    chk("lw/back_idle_ready", {31'h0, req_ready}, 32'h1);
    chk("lw/back_idle_valid", {31'h0, resp_valid}, 32'h0);

    // Sub-word loads with sign/zero extension
    load_chk("lb", 2'b00, 1'b0, 32'h0000_2003, 32'h80FF_0000, 32'hFFFF_FF80);
    load_chk("lbu", 2'b00, 1'b1, 32'h0000_2003, 32'h80FF_0000, 32'h0000_0080);
    load_chk("lh", 2'b01, 1'b0, 32'h0000_2002, 32'h80FF_0000, 32'hFFFF_80FF);
    load_chk("lhu", 2'b01, 1'b1, 32'h0000_2002, 32'h80FF_0000, 32'h0000_80FF);
    load_chk("lb_lane1", 2'b00, 1'b0, 32'h0000_2001, 32'h1234_F678, 32'hFFFF_FFF6);
    load_chk("lh_lane0", 2'b01, 1'b0, 32'h0000_2000, 32'h8000_7FFE, 32'h0000_7FFE);
    load_chk("lw_unsigned", 2'b10, 1'b1, 32'h0000_2000, 32'h8765_4321, 32'h8765_4321);

    // Byte store with three wait states
    issue(1'b1, 2'b00, 1'b0, 32'h0000_3002, 32'h1234_56AB);
    #1;
    stall_cnt = stall ? 1 : 0;
    tick;
    req_valid = 1'b0;
    chk("sb/bus_addr", bus_addr, 32'h0000_3000);
    chk("sb/bus_we", {31'h0, bus_we}, 32'h1);
    chk("sb/bus_wstrb", {28'h0, bus_wstrb}, 32'h4);
    for (int i = 0; i < 4; i++) begin
      chk("sb/bus_wdata_stable", bus_wdata, 32'hABAB_ABAB);
      chk("sb/bus_req_held", {31'h0, bus_req}, 32'h1);
      if (stall) stall_cnt++;
      if (i == 3) begin
        bus_ack = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
      end
      tick;
    end
    bus_ack = 1'b0;
    chk("sb/resp_valid", {31'h0, resp_valid}, 32'h1);
    chk("sb/resp_rdata", resp_rdata, 32'h0);
    chk("sb/resp_err", {31'h0, resp_err}, 32'h0);
    chk("sb/stall_resp", {31'h0, stall}, 32'h0);
    chk("sb/stall_cycles", stall_cnt, 32'd5);
    tick;

    // Half and word store strobes
    issue(1'b1, 2'b01, 1'b0, 32'h0000_4002, 32'h0000_BEEF);
    tick;
    req_valid = 1'b0;
    chk("sh/bus_wstrb", {28'h0, bus_wstrb}, 32'hC);
    chk("sh/bus_wdata", bus_wdata, 32'hBEEF_BEEF);
    bus_ack = 1'b1;
    tick;
    bus_ack = 1'b0;
    tick;
    issue(1'b1, 2'b10, 1'b0, 32'h0000_4000, 32'hCAFE_1234);
    tick;
    req_valid = 1'b0;
    chk("sw/bus_wstrb", {28'h0, bus_wstrb}, 32'hF);
    chk("sw/bus_wdata", bus_wdata, 32'hCAFE_1234);
    bus_ack = 1'b1;
    tick;
    bus_ack = 1'b0;
    chk("sw/resp_valid", {31'h0, resp_valid}, 32'h1);
    tick;

    // Error paths: misaligned word, illegal size, misaligned half
    issue(1'b1, 2'b10, 1'b0, 32'h0000_5006, 32'h1111_1111);
    tick;
    req_valid = 1'b0;
    chk("sw_mis/resp_valid", {31'h0, resp_valid}, 32'h1);
    chk("sw_mis/resp_err", {31'h0, resp_err}, 32'h1);
    chk("sw_mis/bus_req", {31'h0, bus_req}, 32'h0);
    chk("sw_mis/resp_rdata", resp_rdata, 32'h0);
    chk("sw_mis/stall", {31'h0, stall}, 32'h0);
    tick;
    chk("sw_mis/pulse_end", {31'h0, resp_valid}, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 32'h0000_5000, 32'h0);
    tick;
    req_valid = 1'b0;
    chk("size11/resp_err", {31'h0, resp_err}, 32'h1);
    chk("size11/bus_req", {31'h0, bus_req}, 32'h0);
    tick;
    issue(1'b0, 2'b01, 1'b0, 32'h0000_5001, 32'h0);
    tick;
    req_valid = 1'b0;
    chk("lh_mis/resp_err", {31'h0, resp_err}, 32'h1);
    tick;

    // Ack outside BUS is ignored
    bus_ack = 1'b1;
    tick;
    bus_ack = 1'b0;
    chk("idle_ack/resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("idle_ack/req_ready", {31'h0, req_ready}, 32'h1);

    // New request while in BUS is ignored
    issue(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0);
    tick;
    issue(1'b1, 2'b00, 1'b0, 32'h0000_7001, 32'h55);
    tick;
    chk("busy_req/bus_addr", bus_addr, 32'h0000_6000);
    chk("busy_req/bus_we", {31'h0, bus_we}, 32'h0);
    req_valid = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = 32'h0BAD_F00D;
    tick;
    bus_ack = 1'b0;
    chk("busy_req/resp_rdata", resp_rdata, 32'h0BAD_F00D);
    tick;

    // Reset in the 2nd BUS cycle, then a late ack
    issue(1'b0, 2'b10, 1'b0, 32'h0000_8000, 32'h0);
    tick;
    req_valid = 1'b0;
    tick;
    cpu_rst = 1'b1;
    tick;
    cpu_rst = 1'b0;
    chk("midrst/bus_req", {31'h0, bus_req}, 32'h0);
    chk("midrst/req_ready", {31'h0, req_ready}, 32'h1);
    chk("midrst/resp_valid", {31'h0, resp_valid}, 32'h0);
    bus_ack = 1'b1;
    bus_rdata = 32'h1234_5678;
    tick;
    bus_ack = 1'b0;
    chk("midrst/late_ack_valid", {31'h0, resp_valid}, 32'h0);
    chk("midrst/late_ack_busreq", {31'h0, bus_req}, 32'h0);
    tick;
    chk("midrst/late_ack_valid2", {31'h0, resp_valid}, 32'h0);

`ifdef LSU_TIMEOUT_EN
    // No ack: bus_req for exactly 4 cycles, then error response
    issue(1'b0, 2'b10, 1'b0, 32'h0000_9000, 32'h0);
    tick;
    req_valid = 1'b0;
    n = 0;
    while (bus_req && n < 10) begin
      n++;
      tick;
    end
    chk("timeout/bus_req_cycles", n, 32'd4);
    chk("timeout/resp_valid", {31'h0, resp_valid}, 32'h1);
    chk("timeout/resp_err", {31'h0, resp_err}, 32'h1);
    chk("timeout/resp_rdata", resp_rdata, 32'h0);
    tick;
    // Ack on the 4th cycle wins
    issue(1'b0, 2'b10, 1'b0, 32'h0000_9004, 32'h0);
    tick;
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        bus_ack = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
      end
      tick;
    end
    bus_ack = 1'b0;
    chk("ack_last/resp_valid", {31'h0, resp_valid}, 32'h1);
    chk("ack_last/resp_err", {31'h0, resp_err}, 32'h0);
    chk("ack_last/resp_rdata", resp_rdata, 32'hCAFE_F00D);
    tick;
`else
    n = 0;
    stall_cnt = n;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
